// File: rtl/fft_pkg.sv
// Shared types and constants for the in-place radix-2 FFT datapath.
// bitrev() is also used by the sample loader to produce bit-reversed write order.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LOG2N_DEF  = 4;
    localparam int RD_LAT_DEF = 1;
    localparam int BF_LAT_DEF = 4;

    // Widest address the helper supports; callers pass the live width in n.
    localparam int BR_W = 16;

    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] x, input int n);
        logic [BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            if (i < n) begin
                r[n-1-i] = x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address/twiddle generator: (stage, j) -> operand pair and twiddle index, zero latency.
// Purely combinational; FFT_SCHED_BITREV_EN bit-reverses the stage-0 read pair only.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [LOG2N-2:0] stage,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] rd_a,
    output logic [LOG2N-1:0] rd_b,
    output logic [LOG2N-1:0] wr_a,
    output logic [LOG2N-1:0] wr_b,
    output logic [LOG2N-2:0] tw
);

    localparam int W = LOG2N;

    logic [W-1:0] s;
    logic [W-1:0] jw;
    logic [W-1:0] h;
    logic [W-1:0] mask;
    logic [W-1:0] a;
    logic [W-1:0] b;

    always_comb begin
        s    = W'(stage);
        jw   = W'(j);
        h    = W'(1) << s;
        mask = h - W'(1);
        // Insert a zero at bit s of j: the A operand of the pair that straddles distance h.
        a    = ((jw >> s) << (s + W'(1))) | (jw & mask);
        b    = a + h;
        tw   = (W-1)'((jw & mask) << (W'(W - 1) - s));
        wr_a = a;
        wr_b = b;
        rd_a = a;
        rd_b = b;
`ifdef FFT_SCHED_BITREV_EN
        // Stage 0 reads bank 0 and writes bank 1, so only the reads need reordering.
        if (stage == '0) begin
            rd_a = W'(bitrev(BR_W'(a), W));
            rd_b = W'(bitrev(BR_W'(b), W));
        end
`endif
    end

endmodule

// File: rtl/fft_bf_sched.sv
// Sequences one shared radix-2 butterfly through a full in-place N-point DIT FFT (FFT_SCHED_BITREV_EN optional).
// Latency: writes trail reads by RD_LAT+BF_LAT cycles; done after LOG2N*(N/2+RD_LAT+BF_LAT) cycles.
// No backpressure: start is only sampled in IDLE and is never queued while busy.
module fft_bf_sched
    import fft_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int BF_LAT = BF_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-2:0] stage,
    output logic             rd_en,
    output logic             rd_bank,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic             wr_bank,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int L  = RD_LAT + BF_LAT;
    localparam int SW = LOG2N - 1;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    localparam logic [SW-1:0] J_LAST     = SW'((1 << (LOG2N - 1)) - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(L - 1);

    state_t        state;
    logic [SW-1:0] j;
    logic [CW-1:0] cnt;

    logic [LOG2N-1:0] ag_rd_a;
    logic [LOG2N-1:0] ag_rd_b;
    logic [LOG2N-1:0] ag_wr_a;
    logic [LOG2N-1:0] ag_wr_b;
    logic [SW-1:0]    ag_tw;

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage (stage),
        .j     (j),
        .rd_a  (ag_rd_a),
        .rd_b  (ag_rd_b),
        .wr_a  (ag_wr_a),
        .wr_b  (ag_wr_b),
        .tw    (ag_tw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            j     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        stage <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (j == J_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        rd_en <= 1'b0;
                    end else begin
                        j <= j + SW'(1);
                    end
                end
                DRAIN: begin
                    // The next stage reads the bank this stage is still writing; wait out the pipe.
                    if (cnt == CNT_LAST) begin
                        if (stage == STAGE_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            stage <= stage + SW'(1);
                            j     <= '0;
                            rd_en <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    stage <= '0;
                    j     <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd_bank   = rd_en & stage[0];
    assign rd_addr_a = rd_en ? ag_rd_a : '0;
    assign rd_addr_b = rd_en ? ag_rd_b : '0;
    assign tw_idx    = rd_en ? ag_tw : '0;

    logic [L-1:0]     dl_vld;
    logic [L-1:0]     dl_bank;
    logic [LOG2N-1:0] dl_a [L];
    logic [LOG2N-1:0] dl_b [L];

    // Idle slots carry zeros so the write port reads all-zero whenever wr_en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_vld  <= '0;
            dl_bank <= '0;
            for (int i = 0; i < L; i++) begin
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else begin
            dl_vld  <= {dl_vld[L-2:0], rd_en};
            dl_bank <= {dl_bank[L-2:0], rd_en & ~stage[0]};
            dl_a[0] <= rd_en ? ag_wr_a : '0;
            dl_b[0] <= rd_en ? ag_wr_b : '0;
            for (int i = 1; i < L; i++) begin
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign wr_en     = dl_vld[L-1];
    assign wr_bank   = dl_bank[L-1];
    assign wr_addr_a = dl_a[L-1];
    assign wr_addr_b = dl_b[L-1];

endmodule

// File: tb/tb_fft_bf_sched.sv
// Scoreboard bench for fft_bf_sched: expected reads queued at start, writes queued per read.
module tb_fft_bf_sched;
    import fft_pkg::*;

    localparam int LOG2N   = 4;
    localparam int RD_LAT  = 1;
    localparam int BF_LAT  = 4;
    localparam int N       = 1 << LOG2N;
    localparam int L       = RD_LAT + BF_LAT;
    localparam int RUN_LAT = LOG2N * (N / 2 + L);
`ifdef FFT_SCHED_BITREV_EN
    localparam bit BITREV_ON = 1'b1;
`else
    localparam bit BITREV_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-2:0] stage;
    logic             rd_en;
    logic             rd_bank;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic             wr_bank;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    fft_bf_sched #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOG2N-1:0] ra;
        logic [LOG2N-1:0] rb;
        logic [LOG2N-1:0] wa;
        logic [LOG2N-1:0] wb;
        logic [LOG2N-2:0] tw;
        logic [LOG2N-2:0] stg;
        logic             bank;
        int               due;
    } ent_t;

    ent_t rd_q[$];
    ent_t wr_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    bit   mon_en    = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[LOG2N-1-i] = x[i];
        return r;
    endfunction

    // Textbook DIT loop nest: span h, groups of 2h, twiddle step N/(2h).
    task automatic push_run();
        ent_t e;
        for (int s = 0; s < LOG2N; s++) begin
            int h = 1 << s;
            for (int g = 0; g < N; g += 2 * h) begin
                for (int k = 0; k < h; k++) begin
                    e.wa   = LOG2N'(g + k);
                    e.wb   = LOG2N'(g + k + h);
                    e.ra   = (BITREV_ON && s == 0) ? rev(e.wa) : e.wa;
                    e.rb   = (BITREV_ON && s == 0) ? rev(e.wb) : e.wb;
                    e.tw   = (LOG2N-1)'(k * (N / (2 * h)));
                    e.stg  = (LOG2N-1)'(s);
                    e.bank = s[0];
                    e.due  = 0;
                    rd_q.push_back(e);
                end
            end
        end
    endtask

    ent_t me;
    ent_t mw;
    bit   haz;

    always @(negedge clk) begin
        if (mon_en && rd_en) begin
            total_cnt++;
            if (rd_q.size() == 0) begin
                $display("FAIL rd_unexpected cyc=%0d got a=%0d b=%0d want none", cyc, rd_addr_a, rd_addr_b);
            end else begin
                me = rd_q.pop_front();
                if ({rd_bank, stage, rd_addr_a, rd_addr_b, tw_idx} !== {me.bank, me.stg, me.ra, me.rb, me.tw})
                    $display("FAIL rd_addr cyc=%0d got bank=%0d stg=%0d a=%0d b=%0d tw=%0d want bank=%0d stg=%0d a=%0d b=%0d tw=%0d",
                             cyc, rd_bank, stage, rd_addr_a, rd_addr_b, tw_idx, me.bank, me.stg, me.ra, me.rb, me.tw);
                else pass_cnt++;
                total_cnt++;
                haz = 1'b0;
                foreach (wr_q[i]) if (wr_q[i].stg != me.stg) haz = 1'b1;
                if (haz) $display("FAIL rd_hazard cyc=%0d got pending_prev_stage=1 want 0", cyc);
                else pass_cnt++;
                me.bank = ~me.stg[0];
                me.due  = cyc + L;
                wr_q.push_back(me);
            end
        end
        if (mon_en && wr_en) begin
            total_cnt++;
            if (wr_q.size() == 0) begin
                $display("FAIL wr_unexpected cyc=%0d got a=%0d b=%0d want none", cyc, wr_addr_a, wr_addr_b);
            end else begin
                mw = wr_q.pop_front();
                if ({wr_bank, wr_addr_a, wr_addr_b} !== {mw.bank, mw.wa, mw.wb} || cyc != mw.due)
                    $display("FAIL wr_addr cyc=%0d got bank=%0d a=%0d b=%0d want bank=%0d a=%0d b=%0d cyc=%0d",
                             cyc, wr_bank, wr_addr_a, wr_addr_b, mw.bank, mw.wa, mw.wb, mw.due);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, done, rd_en, rd_bank, wr_en, wr_bank, stage, tw_idx} !== '0)
            $display("FAIL reset_ctrl got %b want 0", {busy, done, rd_en, rd_bank, wr_en, wr_bank, stage, tw_idx});
        else pass_cnt++;
        total_cnt++;
        if ({rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b} !== '0)
            $display("FAIL reset_addr got %h want 0", {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b});
        else pass_cnt++;
        @(posedge clk) #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single_run();
        int c0 = 0, first_busy = -1, first_rd = -1, first_wr = -1, done_cyc = -1;
        int busy_n = 0, done_n = 0;
        logic [LOG2N-1:0] fw_a = '0, fw_b = '0;
        logic fw_bank = 1'b0;
        push_run();
        @(posedge clk) #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk) #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (rd_en && first_rd < 0) first_rd = cyc;
            if (wr_en && first_wr < 0) begin
                first_wr = cyc;
                fw_a = wr_addr_a;
                fw_b = wr_addr_b;
                fw_bank = wr_bank;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
        total_cnt++;
        if (first_busy != c0 + 1 || first_rd != c0 + 1)
            $display("FAIL run_start got busy@%0d rd@%0d want both @%0d", first_busy, first_rd, c0 + 1);
        else pass_cnt++;
        total_cnt++;
        if (busy_n != RUN_LAT + 1) $display("FAIL run_busy_len got %0d want %0d", busy_n, RUN_LAT + 1);
        else pass_cnt++;
        total_cnt++;
        if (done_n != 1 || done_cyc - first_rd != RUN_LAT)
            $display("FAIL run_done got n=%0d at %0d want n=1 at %0d", done_n, done_cyc - first_rd, RUN_LAT);
        else pass_cnt++;
        total_cnt++;
        if (first_wr - first_rd != L) $display("FAIL run_wr_lat got %0d want %0d", first_wr - first_rd, L);
        else pass_cnt++;
        total_cnt++;
        if ({fw_bank, fw_a, fw_b} !== {1'b1, LOG2N'(0), LOG2N'(1)})
            $display("FAIL run_first_wr got bank=%0d a=%0d b=%0d want bank=1 a=0 b=1", fw_bank, fw_a, fw_b);
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL run_drain got rd_left=%0d wr_left=%0d want 0 0", rd_q.size(), wr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1, n_done = 0, post_busy = 0;
        logic b_gap = 1'bx, b_rest = 1'bx;
        push_run();
        push_run();
        @(posedge clk) #1;
        start = 1'b1;
        for (int i = 0; i < 400 && n_done < 2; i++) begin
            @(negedge clk);
            if (n_done == 1 && cyc == d1 + 1) b_gap = busy;
            if (n_done == 1 && cyc == d1 + 2) b_rest = busy;
            if (n_done == 1 && cyc == d1 + 3) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) d1 = cyc;
                else d2 = cyc;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) post_busy++;
        end
        total_cnt++;
        if (n_done != 2) $display("FAIL b2b_runs got %0d want 2", n_done);
        else pass_cnt++;
        total_cnt++;
        if (b_gap !== 1'b0 || b_rest !== 1'b1)
            $display("FAIL b2b_gap got idle_busy=%b next_busy=%b want 0 1", b_gap, b_rest);
        else pass_cnt++;
        total_cnt++;
        if (d2 - d1 != RUN_LAT + 2) $display("FAIL b2b_period got %0d want %0d", d2 - d1, RUN_LAT + 2);
        else pass_cnt++;
        total_cnt++;
        if (post_busy != 0) $display("FAIL b2b_no_queue got busy_cycles=%0d want 0", post_busy);
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL b2b_drain got rd_left=%0d wr_left=%0d want 0 0", rd_q.size(), wr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        bit found = 1'b0;
        int stale = 0;
        push_run();
        @(posedge clk) #1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rd_en && stage == (LOG2N-1)'(2)) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL midrun_reach got stage2_run=0 want 1");
        else pass_cnt++;
        @(posedge clk) #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        rd_q.delete();
        wr_q.delete();
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, done, rd_en, rd_bank, wr_en, wr_bank, stage, tw_idx,
             rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b} !== '0)
            $display("FAIL midrun_outputs got %h want 0", {busy, done, rd_en, rd_bank, wr_en, wr_bank, stage, tw_idx,
                                                          rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b});
        else pass_cnt++;
        total_cnt++;
        if (dut.state !== IDLE) $display("FAIL midrun_state got %0d want %0d", dut.state, IDLE);
        else pass_cnt++;
        @(posedge clk) #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en || busy) stale++;
        end
        total_cnt++;
        if (stale != 0) $display("FAIL midrun_stale got %0d active cycles want 0", stale);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_single_run();
        test_back_to_back();
        test_reset_midrun();
        test_single_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
